// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: FSM states, default sizes and
// the destination-legality helper.
package wb_stage_pkg;

  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned WORD_COUNT  = 15;
  localparam int unsigned MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  function automatic logic dest_legal(input int unsigned dest,
                                      input int unsigned count);
    return dest < count;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage handshake, load-data return and register-file write port of
// the write-back stage.
interface wb_stage_if #(
  parameter int unsigned WordLen = 32,
  parameter int unsigned AddrW   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               wb_en_in;
  logic               mem_r_en_in;
  logic               sclr_in;
  logic [AddrW-1:0]   dest_in;
  logic [WordLen-1:0] alu_result_in;
  logic [WordLen-1:0] mem_data_in;
  logic               mem_data_valid;
  logic               writeBackEn;
  logic               sclr;
  logic [AddrW-1:0]   Dest_wb;
  logic [WordLen-1:0] Result_WB;

  modport master (
    output in_valid, wb_en_in, mem_r_en_in, sclr_in, dest_in, alu_result_in,
           mem_data_in, mem_data_valid,
    input  in_ready, writeBackEn, sclr, Dest_wb, Result_WB
  );

  modport slave (
    input  in_valid, wb_en_in, mem_r_en_in, sclr_in, dest_in, alu_result_in,
           mem_data_in, mem_data_valid,
    output in_ready, writeBackEn, sclr, Dest_wb, Result_WB
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Load-wait counter: cleared on load accept, counts enabled cycles and flags
// the cycle on which the wait limit is reached.
module wb_timeout_counter #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] count;

  // expire is high while count sits one below the limit, so the next
  // enabled cycle is the Limit-th wait cycle.
  assign expire = (count == CntW'(Limit - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CntW'(1);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and waits for load data
// before driving the register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned WordLen    = WORD_LEN,
  parameter int unsigned WordCount  = WORD_COUNT,
  parameter int unsigned AddrW      = $clog2(WordCount),
  parameter int unsigned MemTimeout = MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        bus,
  input  logic             freeze,
  output logic             wb_busy,
  output logic [AddrW-1:0] wb_dest,
  output logic             timeout_err,
  output logic             illegal_dest_err,
  output logic [31:0]      retired_count
);

  state_t             state;
  logic               wbe_q;
  logic               sclr_q;
  logic [AddrW-1:0]   dest_q;
  logic [WordLen-1:0] result_q;
  logic [AddrW-1:0]   ld_dest;
  logic               ld_wb_en;
  logic               ld_sclr;

  logic in_ready;
  logic accept;
  logic in_legal;
  logic ld_legal;
  logic expire;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = bus.in_valid && in_ready && !freeze;
  assign in_legal = dest_legal(32'(bus.dest_in), WordCount);
  assign ld_legal = dest_legal(32'(ld_dest), WordCount);

  assign bus.in_ready    = in_ready;
  assign bus.writeBackEn = wbe_q;
  assign bus.sclr        = sclr_q;
  assign bus.Dest_wb     = dest_q;
  assign bus.Result_WB   = result_q;

  assign wb_busy = (state == WAIT_MEM);
  assign wb_dest = (state == WAIT_MEM) ? ld_dest : dest_q;

  wb_timeout_counter #(
    .Limit(MemTimeout)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (accept && bus.mem_r_en_in),
    .en    ((state == WAIT_MEM) && !freeze && !bus.mem_data_valid),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wbe_q            <= 1'b0;
      sclr_q           <= 1'b0;
      dest_q           <= '0;
      result_q         <= '0;
      ld_dest          <= '0;
      ld_wb_en         <= 1'b0;
      ld_sclr          <= 1'b0;
      timeout_err      <= 1'b0;
      illegal_dest_err <= 1'b0;
      retired_count    <= '0;
    end else if (!freeze) begin
      // Write strobes are single-cycle unless re-asserted below.
      wbe_q  <= 1'b0;
      sclr_q <= 1'b0;
      unique case (state)
        IDLE, WRITE: begin
          state <= IDLE;
          if (accept) begin
            if (bus.mem_r_en_in) begin
              ld_dest  <= bus.dest_in;
              ld_wb_en <= bus.wb_en_in;
              ld_sclr  <= bus.sclr_in;
              state    <= WAIT_MEM;
            end else begin
              wbe_q         <= bus.wb_en_in && !bus.sclr_in && in_legal;
              sclr_q        <= bus.sclr_in && in_legal;
              dest_q        <= bus.dest_in;
              result_q      <= bus.alu_result_in;
              retired_count <= retired_count + 32'd1;
              if (!in_legal) illegal_dest_err <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          // Data arriving on the final wait cycle still completes the load.
          if (bus.mem_data_valid) begin
            wbe_q         <= ld_wb_en && !ld_sclr && ld_legal;
            sclr_q        <= ld_sclr && ld_legal;
            dest_q        <= ld_dest;
            result_q      <= bus.mem_data_in;
            retired_count <= retired_count + 32'd1;
            if (!ld_legal) illegal_dest_err <= 1'b1;
            state <= WRITE;
          end else if (expire) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected register-file
// writes, a table of non-load vectors and directed load/freeze/reset cases.
`define CHK(n, a, e) check(n, 64'(a), 64'(e))

module tb_wb_stage;

  localparam int unsigned WL = 32;
  localparam int unsigned WC = 15;
  localparam int unsigned AW = 4;
  localparam int unsigned MT = 4;

  typedef struct packed {
    logic          wbe;
    logic          sclr;
    logic [AW-1:0] dest;
    logic [WL-1:0] data;
  } wr_t;

  typedef struct {
    logic          wb_en;
    logic          sclr;
    logic [AW-1:0] dest;
    logic [WL-1:0] alu;
    logic          exp_wbe;
    logic          exp_sclr;
    logic          exp_illegal;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze = 1'b0;
  logic          wb_busy;
  logic [AW-1:0] wb_dest;
  logic          timeout_err;
  logic          illegal_dest_err;
  logic [31:0]   retired_count;

  wb_stage_if #(.WordLen(WL), .AddrW(AW)) bus ();

  wb_stage #(
    .WordLen   (WL),
    .WordCount (WC),
    .AddrW     (AW),
    .MemTimeout(MT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .freeze          (freeze),
    .wb_busy         (wb_busy),
    .wb_dest         (wb_dest),
    .timeout_err     (timeout_err),
    .illegal_dest_err(illegal_dest_err),
    .retired_count   (retired_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         exp_q[$];
  logic [31:0] exp_rc = 32'd0;
  logic        freeze_q = 1'b0;

  always @(posedge clk) freeze_q <= freeze;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic wbe, input logic sclr,
                              input logic [AW-1:0] d, input logic [WL-1:0] data);
    wr_t w;
    w.wbe  = wbe;
    w.sclr = sclr;
    w.dest = d;
    w.data = data;
    exp_q.push_back(w);
    exp_rc = exp_rc + 32'd1;
  endtask

  task automatic send(input logic load, input logic wb_en, input logic sclr,
                      input logic [AW-1:0] d, input logic [WL-1:0] alu);
    int unsigned n;
    n = 0;
    bus.in_valid      = 1'b1;
    bus.mem_r_en_in   = load;
    bus.wb_en_in      = wb_en;
    bus.sclr_in       = sclr;
    bus.dest_in       = d;
    bus.alu_result_in = alu;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready: got in_ready=0 after %0d cycles, want 1", n);
    end
    step();
    bus.in_valid    = 1'b0;
    bus.mem_r_en_in = 1'b0;
    bus.wb_en_in    = 1'b0;
    bus.sclr_in     = 1'b0;
  endtask

  task automatic pulse(input logic [WL-1:0] d);
    bus.mem_data_valid = 1'b1;
    bus.mem_data_in    = d;
    step();
    bus.mem_data_valid = 1'b0;
  endtask

  // Every retirement pops one expected write; strobes without a retirement
  // are only legal while a freeze is holding the previous write.
  task automatic monitor();
    logic [31:0] last_rc;
    wr_t e;
    last_rc = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rc = 32'd0;
      end else if (retired_count != last_rc) begin
        `CHK("retire_step", retired_count, last_rc + 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got write to dest %0d, want none", bus.Dest_wb);
        end else begin
          e = exp_q.pop_front();
          `CHK("sb_wbe", bus.writeBackEn, e.wbe);
          `CHK("sb_sclr", bus.sclr, e.sclr);
          `CHK("sb_dest", bus.Dest_wb, e.dest);
          `CHK("sb_data", bus.Result_WB, e.data);
        end
        last_rc = retired_count;
      end else if ((bus.writeBackEn || bus.sclr) && !freeze_q) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_write: got wbe=%0b sclr=%0b, want 0", bus.writeBackEn, bus.sclr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 1'b1, 4'd7,  32'h100, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd15, 32'h200, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 4'd4,  32'h300, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 4'd14, 32'h400, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 4'd0,  32'h500, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'd15, 32'h600, 1'b0, 1'b0, 1'b1};

    bus.in_valid       = 1'b0;
    bus.wb_en_in       = 1'b0;
    bus.mem_r_en_in    = 1'b0;
    bus.sclr_in        = 1'b0;
    bus.dest_in        = '0;
    bus.alu_result_in  = '0;
    bus.mem_data_in    = '0;
    bus.mem_data_valid = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_wbe", bus.writeBackEn, 1'b0);
    `CHK("rst_sclr", bus.sclr, 1'b0);
    `CHK("rst_dest", bus.Dest_wb, 4'd0);
    `CHK("rst_result", bus.Result_WB, 32'd0);
    `CHK("rst_busy", wb_busy, 1'b0);
    `CHK("rst_count", retired_count, 32'd0);
    `CHK("rst_errs", {timeout_err, illegal_dest_err}, 2'b00);
    rst = 1'b0;
    step();
    `CHK("idle_ready", bus.in_ready, 1'b1);

    // Non-load: one-cycle latency, strobe drops, data holds
    expect_write(1'b1, 1'b0, 4'd3, 32'h1234);
    send(1'b0, 1'b1, 1'b0, 4'd3, 32'h1234);
    `CHK("t1_wbe", bus.writeBackEn, 1'b1);
    `CHK("t1_dest", bus.Dest_wb, 4'd3);
    `CHK("t1_result", bus.Result_WB, 32'h1234);
    `CHK("t1_count", retired_count, 32'd1);
    step();
    `CHK("t1_wbe_drop", bus.writeBackEn, 1'b0);
    `CHK("t1_dest_hold", bus.Dest_wb, 4'd3);
    `CHK("t1_result_hold", bus.Result_WB, 32'h1234);

    // Load with data three cycles after accept, then WRITE accepts a non-load
    send(1'b1, 1'b1, 1'b0, 4'd5, 32'hA5A5);
    for (int i = 0; i < 3; i++) begin
      `CHK("t2_busy", wb_busy, 1'b1);
      `CHK("t2_ready", bus.in_ready, 1'b0);
      `CHK("t2_wb_dest", wb_dest, 4'd5);
      `CHK("t2_wbe_low", bus.writeBackEn, 1'b0);
      if (i < 2) step();
    end
    expect_write(1'b1, 1'b0, 4'd5, 32'hDEADBEEF);
    pulse(32'hDEADBEEF);
    `CHK("t2_wbe", bus.writeBackEn, 1'b1);
    `CHK("t2_dest", bus.Dest_wb, 4'd5);
    `CHK("t2_result", bus.Result_WB, 32'hDEADBEEF);
    `CHK("t2_busy_clr", wb_busy, 1'b0);
    `CHK("t2_ready_set", bus.in_ready, 1'b1);
    expect_write(1'b1, 1'b0, 4'd1, 32'h77);
    send(1'b0, 1'b1, 1'b0, 4'd1, 32'h77);
    `CHK("t2_write_accept_dest", bus.Dest_wb, 4'd1);
    `CHK("t2_count", retired_count, exp_rc);

    // Data on the last allowed wait cycle completes the load
    send(1'b1, 1'b1, 1'b0, 4'd2, 32'h0);
    repeat (3) step();
    expect_write(1'b1, 1'b0, 4'd2, 32'h00C0FFEE);
    pulse(32'h00C0FFEE);
    `CHK("t2b_wbe", bus.writeBackEn, 1'b1);
    `CHK("t2b_result", bus.Result_WB, 32'h00C0FFEE);
    `CHK("t2b_timeout", timeout_err, 1'b0);

    // Data pulses outside WAIT_MEM are ignored
    pulse(32'hBAD0);
    pulse(32'hBAD1);
    `CHK("stray_wbe", bus.writeBackEn, 1'b0);
    `CHK("stray_count", retired_count, exp_rc);

    // Timeout after MT wait cycles, nothing retired
    send(1'b1, 1'b1, 1'b0, 4'd6, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      `CHK("t3_pending", {wb_busy, timeout_err}, 2'b10);
    end
    step();
    `CHK("t3_timeout", timeout_err, 1'b1);
    `CHK("t3_idle", {wb_busy, bus.in_ready}, 2'b01);
    `CHK("t3_no_write", bus.writeBackEn, 1'b0);
    `CHK("t3_count", retired_count, exp_rc);
    step();
    `CHK("t3_sticky", timeout_err, 1'b1);

    // Table of back-to-back non-loads: sclr priority and illegal destinations
    `CHK("t4_illegal_pre", illegal_dest_err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      expect_write(vecs[i].exp_wbe, vecs[i].exp_sclr, vecs[i].dest, vecs[i].alu);
      send(1'b0, vecs[i].wb_en, vecs[i].sclr, vecs[i].dest, vecs[i].alu);
      `CHK("t4_wbe", bus.writeBackEn, vecs[i].exp_wbe);
      `CHK("t4_sclr", bus.sclr, vecs[i].exp_sclr);
      `CHK("t4_illegal", illegal_dest_err, vecs[i].exp_illegal);
    end
    `CHK("t4_count", retired_count, exp_rc);

    // Freeze during WAIT_MEM swallows the pulse; freeze after write holds it
    send(1'b1, 1'b1, 1'b0, 4'd9, 32'h9);
    step();
    freeze             = 1'b1;
    bus.mem_data_valid = 1'b1;
    bus.mem_data_in    = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      step();
      `CHK("t5_frozen_busy", {wb_busy, bus.in_ready}, 2'b10);
      `CHK("t5_frozen_wbe", bus.writeBackEn, 1'b0);
      `CHK("t5_frozen_dest", wb_dest, 4'd9);
    end
    freeze             = 1'b0;
    bus.mem_data_valid = 1'b0;
    step();
    `CHK("t5_still_busy", wb_busy, 1'b1);
    expect_write(1'b1, 1'b0, 4'd9, 32'h22222222);
    pulse(32'h22222222);
    `CHK("t5_wbe", bus.writeBackEn, 1'b1);
    `CHK("t5_result", bus.Result_WB, 32'h22222222);
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      `CHK("t5_hold_wbe", bus.writeBackEn, 1'b1);
      `CHK("t5_hold_count", retired_count, exp_rc);
    end
    freeze = 1'b0;
    step();
    `CHK("t5_release_wbe", bus.writeBackEn, 1'b0);

    // Asynchronous reset in the middle of WAIT_MEM
    send(1'b1, 1'b1, 1'b0, 4'd10, 32'h0);
    step();
    `CHK("t6_busy_pre", wb_busy, 1'b1);
    #2;
    rst = 1'b1;
    #2;
    `CHK("t6_state", {wb_busy, bus.in_ready}, 2'b01);
    `CHK("t6_outs", {bus.writeBackEn, bus.sclr, bus.Dest_wb, wb_dest}, 10'd0);
    `CHK("t6_result", bus.Result_WB, 32'd0);
    `CHK("t6_count", retired_count, 32'd0);
    `CHK("t6_errs", {timeout_err, illegal_dest_err}, 2'b00);
    #2;
    rst    = 1'b0;
    exp_rc = 32'd0;
    step();
    pulse(32'hFEED);
    `CHK("t6_no_write", bus.writeBackEn, 1'b0);
    `CHK("t6_count_post", retired_count, 32'd0);

    step();
    `CHK("sb_drained", exp_q.size(), 0);
    `CHK("final_count", retired_count, exp_rc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
